bcd_to_bin: RTL and testbench

- Sequential BCD-to-binary converter: packed decimal digits in, unsigned binary out.
- Inverse of the team's binary-to-BCD path. Sits on the receive side of the UART link, where decimal digits typed or received as ASCII-stripped nibbles are rebuilt into a 16-bit value.
- Works one digit per clock, most-significant digit first: acc = acc*10 + digit. Uses a start/busy/done handshake and flags invalid digits.

---
 rtl/bcd_to_bin.sv | 92 +++++++++
 tb/tb_bcd_to_bin.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
// Start/busy/done handshake; nibbles above 9 abort the request immediately with err.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] digits_sr;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    acc_next;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          msd;

  function automatic logic bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // acc*10 + d as two shifts and adds; WIDTH is sized so this never wraps
  function automatic logic [WIDTH-1:0] mac10(input logic [WIDTH-1:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + WIDTH'(d);
  endfunction

  assign msd      = digits_sr[4*DIGITS-1 -: 4];
  assign acc_next = mac10(acc, msd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      digits_sr <= '0;
      acc       <= '0;
      cnt       <= '0;
      bin       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            digits_sr <= bcd;
            acc       <= '0;
            cnt       <= '0;
            if (bad_digit(bcd)) begin
              bin  <= '0;
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= CONV;
            end
          end
        end
        CONV: begin
          acc       <= acc_next;
          digits_sr <= digits_sr << 4;
          cnt       <= cnt + 1'b1;
          // last digit folds straight into the result register
          if (cnt == CNT_W'(DIGITS-1)) begin
            bin   <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 16;

  logic                clk   = 1'b0;
  logic                rst   = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd   = '0;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic                err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bcd  (bcd),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  initial begin
    assert ((longint'(1) << WIDTH) > longint'(10**DIGITS) - 1)
      else $fatal(1, "FAIL param_rule: WIDTH=%0d too narrow for DIGITS=%0d", WIDTH, DIGITS);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: value is the plain decimal sum of digit*10^i; timing is "result DIGITS+1 edges later"
  function automatic int dec_val(input logic [4*DIGITS-1:0] v);
    int s;
    int p;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return s;
  endfunction

  function automatic bit any_bad(input logic [4*DIGITS-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  logic [WIDTH-1:0] m_bin  = '0;
  logic [WIDTH-1:0] m_pend = '0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic             m_err  = 1'b0;
  int               m_left = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_bin = '0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_left = 0;
      end else begin
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_bin  = m_pend;
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end else if (start) begin
          if (any_bad(bcd)) begin
            m_bin  = '0;
            m_err  = 1'b1;
            m_done = 1'b1;
          end else begin
            m_err  = 1'b0;
            m_pend = WIDTH'(dec_val(bcd));
            m_left = DIGITS;
            m_busy = 1'b1;
          end
        end
      end
      check("cyc_bin",  32'(bin),  32'(m_bin));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_err",  32'(err),  32'(m_err));
    end
  end

  task automatic run_one(input logic [15:0] v, input logic [15:0] exp_bin, input logic exp_err,
                         input int exp_lat, input string nm);
    int lat;
    int nbusy;
    @(posedge clk); #2; bcd = v; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #2;
      lat++;
    end
    check({nm, "_seen_done"}, 32'(done), 32'd1);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    check({nm, "_bin"}, 32'(bin), 32'(exp_bin));
    check({nm, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!done && lat < 20);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    int lat;
    int ndone;
    logic [15:0] got;

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 32'({bin, busy, done, err}), 32'd0);
    rst = 1'b0;

    run_one(16'h1234, 16'h04D2, 1'b0, 5, "bcd1234");
    run_one(16'h9999, 16'h270F, 1'b0, 5, "bcd9999");
    run_one(16'h0000, 16'h0000, 1'b0, 5, "bcd0000");
    run_one(16'h12A4, 16'h0000, 1'b1, 1, "bad_tens");
    run_one(16'h0042, 16'h002A, 1'b0, 5, "bcd0042");

    // Extra starts during conversion must be ignored
    @(posedge clk); #2; bcd = 16'h0500; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2; start = 1'b1; bcd = 16'h7777;
    @(posedge clk); #2;
    @(posedge clk); #2; start = 1'b0; bcd = 16'h0000;
    ndone = 0;
    got   = 16'hFFFF;
    repeat (8) begin
      if (done) begin ndone++; got = bin; end
      @(posedge clk); #2;
    end
    check("ignore_start_done_count", 32'(ndone), 32'd1);
    check("ignore_start_bin", 32'(got), 32'h01F4);

    // Back-to-back with start held high
    @(posedge clk); #2; bcd = 16'h0001; start = 1'b1;
    wait_done(lat);
    check("b2b_first_lat", 32'(lat), 32'd5);
    check("b2b_first_bin", 32'(bin), 32'd1);
    bcd = 16'h0010;
    wait_done(lat);
    check("b2b_second_lat", 32'(lat), 32'd5);
    check("b2b_second_bin", 32'(bin), 32'd10);
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during the second conversion cycle
    @(posedge clk); #2; bcd = 16'h8888; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    check("abort_outputs", 32'({bin, busy, done, err}), 32'd0);
    repeat (6) begin
      @(posedge clk); #2;
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_one(16'h0007, 16'h0007, 1'b0, 5, "after_abort");

    // Randomized traffic, model checks every cycle
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      rst   = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) bcd = rand_bcd();
    end
    @(posedge clk); #2; rst = 1'b0; start = 1'b0;
    repeat (8) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
